// File: rtl/approx_add_pipe.sv
// Two-stage approximate adder: the low K bits are added separately and the carry into the
// upper part is exact, dropped or speculated. Results carry an error flag and feed a saturating error counter.
module approx_add_pipe #(
   parameter int N    = 32,
   parameter int KMAX = 16,
   parameter int KW   = $clog2(KMAX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   input  logic [KW-1:0] k_sel,
   input  logic [1:0]    mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  sum,
   output logic          err_flag,
   input  logic          clr_cnt,
   output logic [15:0]   err_cnt
);

   // Handshake: a beat moves on any cycle where valid & ready are both high. The sender
   // holds valid and data steady until it sees ready. The receiver may raise ready at any time.
   logic          s1_valid, s2_valid;
   logic          s1_load, s2_load, accept;
   logic [N-1:0]  s1_low, s1_ahi, s1_bhi, s1_cin, s1_exact;
   logic [N-1:0]  s2_sum;
   logic          s2_err;

   logic [KW-1:0] k_eff;
   logic [N-1:0]  mask, top_mask, upper, sum_d;
   logic [N:0]    low_full, carry_pos;
   logic          c_exact, c_spec, c;

   assign k_eff = (k_sel > KW'(KMAX)) ? KW'(KMAX) : k_sel;
   assign mask     = ~({N{1'b1}} << k_eff);
   // Selects bit K-1 alone; empty when K = 0, so speculation never fires there.
   assign top_mask = mask ^ (mask >> 1);
   assign low_full  = {1'b0, a & mask} + {1'b0, b & mask};
   assign carry_pos = {{N{1'b0}}, 1'b1} << k_eff;
   assign c_exact   = |(low_full & carry_pos);
   assign c_spec    = |(a & b & top_mask);

   always_comb begin
      c = c_exact;
      case (mode)
         2'b01:   c = 1'b0;
         2'b10:   c = c_spec;
         default: c = c_exact;
      endcase
   end

   assign s2_load  = !s2_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = !rst && s1_load;
   assign accept   = in_valid && in_ready;

   // Upper operands have zero low bits, so OR-ing in the kept low part is a concatenation.
   assign upper = s1_ahi + s1_bhi + s1_cin;
   assign sum_d = upper | s1_low;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_low   <= '0;
         s1_ahi   <= '0;
         s1_bhi   <= '0;
         s1_cin   <= '0;
         s1_exact <= '0;
         s2_valid <= 1'b0;
         s2_sum   <= '0;
         s2_err   <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
               s1_low   <= low_full[N-1:0] & mask;
               s1_ahi   <= a & ~mask;
               s1_bhi   <= b & ~mask;
               s1_cin   <= c ? carry_pos[N-1:0] : '0;
               s1_exact <= a + b;
            end
         end
         if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_sum <= sum_d;
               s2_err <= (sum_d != s1_exact);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_cnt)
         err_cnt <= '0;
      else if (s2_valid && out_ready && s2_err && (err_cnt != 16'hFFFF))
         err_cnt <= err_cnt + 16'd1;
   end

   assign out_valid = s2_valid;
   assign sum       = s2_sum;
   assign err_flag  = s2_err;

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed bench for approx_add_pipe: hand-computed vectors, back-pressure, reset flush
// and error-counter saturation/clear.
module tb_approx_add_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic [4:0]  k_sel;
   logic [1:0]  mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        err_flag;
   logic        clr_cnt;
   logic [15:0] err_cnt;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   approx_add_pipe #(.N(32), .KMAX(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .k_sel(k_sel), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .err_flag(err_flag),
      .clr_cnt(clr_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] kv, input logic [1:0] mv);
      in_valid = 1'b1; a = av; b = bv; k_sel = kv; mode = mv;
   endtask

   // One beat with out_ready high; checks accept, 2-cycle latency, sum and flag.
   task automatic beat(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] kv, input logic [1:0] mv,
                       input logic [31:0] exp_sum, input logic exp_err);
      step(); drive(av, bv, kv, mv); #1;
      chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      step(); in_valid = 1'b0; #1;
      chk({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
      step(); #1;
      chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_sum"}, sum, exp_sum);
      chk({tag, "_err"}, {31'b0, err_flag}, {31'b0, exp_err});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; k_sel = '0; mode = '0;
      out_ready = 1'b1; clr_cnt = 1'b0;
      step(); step(); #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_sum", sum, 32'd0);
      chk("rst_err", {31'b0, err_flag}, 32'd0);
      chk("rst_cnt", {16'b0, err_cnt}, 32'd0);
      step(); rst = 1'b0;
      step(); #1;
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      // Directed vectors (KMAX = 16)
      beat("drop_k8",   32'h80, 32'h80, 5'd8, 2'b01, 32'h0, 1'b1);
      beat("spec_k8",   32'h80, 32'h80, 5'd8, 2'b10, 32'h100, 1'b0);
      beat("exact_wrap", 32'hFFFF_FFFF, 32'h1, 5'd16, 2'b00, 32'h0, 1'b0);
      beat("clamp_k20", 32'h0001_8000, 32'h0000_8000, 5'd20, 2'b01, 32'h0001_0000, 1'b1);
      beat("mode11",    32'h80, 32'h80, 5'd8, 2'b11, 32'h100, 1'b0);
      beat("k0_drop",   32'hFF, 32'h01, 5'd0, 2'b01, 32'h100, 1'b0);
      beat("spec_miss", 32'h07, 32'h09, 5'd4, 2'b10, 32'h0, 1'b1);
      beat("spec_hit",  32'h0F, 32'h08, 5'd4, 2'b10, 32'h17, 1'b0);
      beat("drop_nocy", 32'h1234_5678, 32'h1111_1111, 5'd16, 2'b01, 32'h2345_6789, 1'b0);
      step(); #1;
      chk("cnt_after_vectors", {16'b0, err_cnt}, 32'd3);

      // Back-pressure: four exact beats with a stalled consumer
      step(); out_ready = 1'b0;
      drive(32'h101, 32'h10, 5'd0, 2'b00); exp_q.push_back(32'h111); #1;
      chk("bp_rdy0", {31'b0, in_ready}, 32'd1);
      step(); drive(32'h201, 32'h10, 5'd0, 2'b00); exp_q.push_back(32'h211); #1;
      chk("bp_rdy1", {31'b0, in_ready}, 32'd1);
      chk("bp_nv1", {31'b0, out_valid}, 32'd0);
      step(); drive(32'h301, 32'h10, 5'd0, 2'b00); exp_q.push_back(32'h311); #1;
      chk("bp_rdy2_low", {31'b0, in_ready}, 32'd0);
      chk("bp_v2", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_a", sum, exp_q[0]);
      step(); #1;
      chk("bp_rdy3_low", {31'b0, in_ready}, 32'd0);
      chk("bp_hold_b", sum, exp_q[0]);
      step(); out_ready = 1'b1; #1;
      chk("bp_rdy4", {31'b0, in_ready}, 32'd1);
      e = exp_q.pop_front(); chk("bp_out0", sum, e);
      step(); drive(32'h401, 32'h10, 5'd0, 2'b00); exp_q.push_back(32'h411); #1;
      chk("bp_rdy5", {31'b0, in_ready}, 32'd1);
      e = exp_q.pop_front(); chk("bp_out1", sum, e);
      step(); in_valid = 1'b0; #1;
      chk("bp_v6", {31'b0, out_valid}, 32'd1);
      e = exp_q.pop_front(); chk("bp_out2", sum, e);
      step(); #1;
      chk("bp_v7", {31'b0, out_valid}, 32'd1);
      e = exp_q.pop_front(); chk("bp_out3", sum, e);
      step(); #1;
      chk("bp_drained", {31'b0, out_valid}, 32'd0);

      // Reset with two erroneous beats in flight
      step(); out_ready = 1'b0; drive(32'h80, 32'h80, 5'd8, 2'b01);
      step(); drive(32'h80, 32'h80, 5'd8, 2'b01);
      step(); in_valid = 1'b0; rst = 1'b1; #1;
      chk("flush_rdy_in_rst", {31'b0, in_ready}, 32'd0);
      step(); rst = 1'b0; out_ready = 1'b1; #1;
      chk("flush_nv0", {31'b0, out_valid}, 32'd0);
      chk("flush_cnt", {16'b0, err_cnt}, 32'd0);
      step(); #1;
      chk("flush_nv1", {31'b0, out_valid}, 32'd0);
      step(); #1;
      chk("flush_nv2", {31'b0, out_valid}, 32'd0);

      // Saturation: 65535 erroneous beats reach FFFF, two more hold it there
      for (int i = 0; i < 65535; i++) begin
         step(); drive(32'h80 + 32'(($urandom_range(0, 255)) << 8), 32'h80, 5'd8, 2'b01);
      end
      step(); in_valid = 1'b0;
      step(); step(); #1;
      chk("cnt_ffff", {16'b0, err_cnt}, 32'h0000_FFFF);
      step(); drive(32'h80, 32'h80, 5'd8, 2'b01);
      step(); drive(32'h80, 32'h80, 5'd8, 2'b01);
      step(); in_valid = 1'b0;
      step(); step(); #1;
      chk("cnt_sat", {16'b0, err_cnt}, 32'h0000_FFFF);

      // Clear coinciding with an erroneous handshake
      step(); drive(32'h80, 32'h80, 5'd8, 2'b01);
      step(); in_valid = 1'b0;
      step(); clr_cnt = 1'b1; #1;
      chk("clr_hs_valid", {31'b0, out_valid & err_flag}, 32'd1);
      step(); clr_cnt = 1'b0; #1;
      chk("clr_wins", {16'b0, err_cnt}, 32'd0);
      beat("after_clr", 32'h80, 32'h80, 5'd8, 2'b01, 32'h0, 1'b1);
      step(); #1;
      chk("cnt_one", {16'b0, err_cnt}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
